alu_nibble_seq: RTL and testbench
=================================

Name: alu_nibble_seq

Overview:
Multi-cycle sequencer that performs wide ALU operations by time-sharing one 4-bit ALU nibble datapath. It processes one nibble per cycle, LSB first, and carries between nibbles through a register. It sits between a host (start/done handshake) and the 4-bit ALU, and trades latency for area compared with a full-width ripple chain.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; data width W = 4*NIBBLES; legal range 2..8.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  request pulse; sampled only when not busy.
op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
a  input  W  operand A; latched on accepted start.
b  input  W  operand B; latched on accepted start.
cin  input  1  carry-in for ADD; latched on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result, cout and zero are valid.
result  output  W  operation result; held until the next accepted start.
cout  output  1  carry out of the MSB nibble (ADD/SUB); 0 for AND/OR.
zero  output  1  result == 0; updated together with done.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On rst, all outputs are 0, state is IDLE, and the nibble index and carry register are 0.
- FSM states:
  - IDLE: start=1 latches a, b, op and cin, clears result, and moves to RUN.
  - RUN: one nibble per edge, index i = 0..NIBBLES-1. On i = NIBBLES-1, move to DONE.
  - DONE: lasts one cycle with done=1. start=1 in DONE is accepted (back-to-back, goes to RUN); otherwise go to IDLE.
- Latency: start sampled at edge k gives done=1 during the cycle following edge k+NIBBLES. Throughput is one operation per NIBBLES+1 cycles.
- Nibble datapath:
  - ADD: a_i + b_i + c. Initial c = latched cin.
  - SUB: a_i + ~b_i + c. Initial c = 1; cin is ignored. cout=1 means no borrow.
  - AND/OR: bitwise on the nibble. The carry register is forced to 0.
  - The carry register captures each nibble's carry-out. The final value drives cout.
- Result write: result[4i+3:4i] is written at RUN edge i. Intermediate partial values are visible, but valid only while done=1 or after it. zero is computed from the full result and registered at the DONE transition.
- start while busy=1: ignored. No queueing, no error.
- Operand changes during RUN: no effect, because operands are latched.
- Reset mid-RUN: immediate abort. All outputs return to 0 and no done pulse is issued.
- Arithmetic is unsigned modulo 2^W; no saturation.

Optional Feature:
Macro ALU_SEQ_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit). It gives signed two's-complement overflow for ADD/SUB, equal to carry-into-MSB XOR carry-out-of-MSB in the last nibble. It is 0 for AND/OR, reset to 0, and updated with done.
- Undefined: no ovf port and no extra logic.

Decomposition:
- Package alu_seq_pkg contains:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - FSM state typedef {S_IDLE, S_RUN, S_DONE};
  - NIBBLE_W=4.
- Sub-module alu_nibble_core: combinational 4-bit ALU with inputs a[3:0], b[3:0], cin, op and outputs y[3:0], cout, c3 (carry into bit 3, used for ovf). The sequencer instantiates it once and muxes nibbles into it by index.

Test Plan:
- NIBBLES=4, ADD a=16'hFFFF, b=16'h0001, cin=0 -> done exactly 4 cycles after the start edge; result=16'h0000, cout=1, zero=1.
- SUB a=16'h1234, b=16'h1235 -> result=16'hFFFF, cout=0, zero=0. Repeat with b=16'h1234 -> result=0, cout=1, zero=1.
- AND a=16'hF0F0, b=16'h0FF0 -> 16'h00F0, cout=0. OR with the same operands -> 16'hFFF0.
- Pulse start again 2 cycles into RUN with different operands -> ignored; first result delivered unchanged; a single done pulse. Then start in the DONE cycle -> accepted back-to-back.
- Assert rst asynchronously mid-RUN (between edges) -> busy, result and done drop to 0 immediately; no done pulse; a new start afterwards completes normally.
- With ALU_SEQ_OVERFLOW_EN: ADD 16'h7FFF + 16'h0001 -> result 16'h8000, ovf=1, cout=0. SUB 16'h8000 - 16'h0001 -> 16'h7FFF, ovf=1.

Source files
------------

// File: rtl/alu_nibble_seq_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer.
// The optional ALU_SEQ_OVERFLOW_EN macro adds the signed-overflow output.
package alu_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef logic [1:0] op_t;
    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_AND = 2'b10;
    localparam op_t OP_OR  = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    function automatic logic is_arith(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // SUB is a + ~b + 1, so the chain starts with a forced carry of 1
    function automatic logic init_carry(input op_t op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = cin;
            OP_SUB:  c = 1'b1;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Host-side start/done bus of the nibble-serial ALU sequencer.
// ALU_SEQ_OVERFLOW_EN adds the ovf signal.
interface alu_nibble_seq_if #(
    parameter int unsigned NIBBLES = 4
);
    import alu_seq_pkg::*;

    localparam int unsigned W = NIBBLE_W * NIBBLES;

    logic         start;
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic         ovf;
`endif

    modport master (
        output start, op, a, b, cin,
`ifdef ALU_SEQ_OVERFLOW_EN
        input  ovf,
`endif
        input  busy, done, result, cout, zero
    );

    modport slave (
        input  start, op, a, b, cin,
`ifdef ALU_SEQ_OVERFLOW_EN
        output ovf,
`endif
        output busy, done, result, cout, zero
    );

endinterface

// File: rtl/alu_nibble_core.sv
// Combinational 4-bit ALU slice: add, subtract (a + ~b + cin), and, or.
module alu_nibble_core
    import alu_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  op_t                 op,
    output logic [NIBBLE_W-1:0] y,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] b_eff;
    logic [NIBBLE_W:0]   sum;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b_eff) + (NIBBLE_W+1)'(cin);
        y     = '0;
        cout  = 1'b0;
        c3    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                y    = sum[NIBBLE_W-1:0];
                cout = sum[NIBBLE_W];
                // carry into the top bit recovered from the sum bit and its operands
                c3   = sum[NIBBLE_W-1] ^ a[NIBBLE_W-1] ^ b_eff[NIBBLE_W-1];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Wide ALU built by time-sharing one 4-bit slice, LSB nibble first.
// ALU_SEQ_OVERFLOW_EN adds a registered signed-overflow flag (bus.ovf).
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_nibble_seq_if.slave bus
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    op_t               op_q, op_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cout_q, cout_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] core_a, core_b, core_y;
    logic                core_cout, core_c3;

    assign core_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign core_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    alu_nibble_core u_core (
        .a    (core_a),
        .b    (core_b),
        .cin  (carry_q),
        .op   (op_q),
        .y    (core_y),
        .cout (core_cout),
        .c3   (core_c3)
    );

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    op_d     = bus.op;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    carry_d  = init_carry(bus.op, bus.cin);
                    idx_d    = '0;
                    result_d = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_d[idx_q*NIBBLE_W +: NIBBLE_W] = core_y;
                carry_d = core_cout;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = core_cout;
                    zero_d  = (result_d == '0);
                    ovf_d   = is_arith(op_q) & (core_c3 ^ core_cout);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;

`ifdef ALU_SEQ_OVERFLOW_EN
    assign bus.ovf = ovf_q;
`else
    // overflow tracking is compiled out; the slice's c3 has no consumer
    logic unused_c3;
    logic unused_ovf;
    assign unused_c3  = core_c3;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Randomized self-checking bench for alu_nibble_seq (NIBBLES=4), with a whole-word reference model.
module tb_alu_nibble_seq;
    import alu_seq_pkg::*;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_nibble_seq_if #(.NIBBLES(NIB)) bus ();

    alu_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: plain modular arithmetic and signed-range reasoning
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output logic [W-1:0] res, output logic co,
                         output logic z, output logic ov);
        logic [W:0] full;
        res = '0; co = 1'b0; ov = 1'b0;
        case (op)
            OP_ADD: begin
                full = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
                res  = full[W-1:0];
                co   = full[W];
                ov   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                res = a - b;
                co  = (a >= b);
                ov  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_AND: res = a & b;
            default: res = a | b;
        endcase
        z = (res == '0);
    endtask

    // Drives start in the current (falling-edge) cycle and checks the whole transaction.
    // Returns in the done cycle so the caller can launch back-to-back.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input bit inject);
        logic [W-1:0] e_res;
        logic e_co, e_z, e_ov;
        int cnt;
        model(op, a, b, cin, e_res, e_co, e_z, e_ov);
        bus.op = op; bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_run", bus.busy, 1);
        check("result_clr", bus.result, 0);
        cnt = 0;
        while (!bus.done && cnt < 20) begin
            if (inject && cnt == 1) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom);
            end
            if (cnt == 2) bus.start = 1'b0;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.cin = 1'($urandom);
            @(negedge clk);
            cnt++;
        end
        bus.start = 1'b0;
        check("latency", cnt, NIB);
        check("result", bus.result, e_res);
        check("cout", bus.cout, e_co);
        check("zero", bus.zero, e_z);
        check("busy_done", bus.busy, 0);
`ifdef ALU_SEQ_OVERFLOW_EN
        check("ovf", bus.ovf, e_ov);
`endif
    endtask

    task automatic idle_step(input string tag);
        @(negedge clk);
        check(tag, bus.done, 0);
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        bit           any_done;

        bus.start = 1'b0; bus.op = OP_ADD; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_zero", bus.zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0); idle_step("pulse_add");
        run_op(OP_SUB, 16'h1234, 16'h1235, 1'b0, 1'b0); idle_step("pulse_sub1");
        run_op(OP_SUB, 16'h1234, 16'h1234, 1'b0, 1'b0); idle_step("pulse_sub2");
        run_op(OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0); idle_step("pulse_and");
        run_op(OP_OR,  16'hF0F0, 16'h0FF0, 1'b0, 1'b0); idle_step("pulse_or");
        run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0); idle_step("pulse_ovf_add");
        run_op(OP_SUB, 16'h8000, 16'h0001, 1'b1, 1'b0); idle_step("pulse_ovf_sub");
        run_op(OP_ADD, 16'h0FFF, 16'hF000, 1'b1, 1'b0); idle_step("pulse_add_cin");

        // Start while busy is ignored, then a start in the done cycle is accepted
        run_op(OP_ADD, 16'h1357, 16'h2468, 1'b1, 1'b1);
        run_op(OP_SUB, 16'h0100, 16'h0200, 1'b0, 1'b0);
        idle_step("pulse_b2b");

        // Asynchronous reset between edges mid-RUN
        bus.op = OP_ADD; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("partial_nib0", bus.result & 32'hF, 3);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) any_done = 1'b1;
        end
        check("abort_no_done", any_done, 0);
        run_op(OP_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0); idle_step("pulse_after_rst");

        // Randomized traffic with occasional boundary operands and back-to-back starts
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom);
            r_a  = W'($urandom);
            case ($urandom_range(0, 4))
                0: r_b = r_a;
                1: r_b = 16'hFFFF;
                2: r_b = '0;
                default: r_b = W'($urandom);
            endcase
            run_op(r_op, r_a, r_b, 1'($urandom), bit'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) idle_step("pulse_rand");
        end
        idle_step("pulse_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
